// File: rtl/avalon_arbiter_2to1.sv
// ============================================================================
// Module      : avalon_arbiter_2to1
// Description : Two-requester Avalon-MM arbiter onto one shared slave, with
//               burst tracking. Define AV_ARB_ROUND_ROBIN_EN for round-robin
//               arbitration; fixed priority (requester 0 first) otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_arbiter_2to1 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,

    input  logic [AW-1:0]   s0_av_address_i,
    input  logic [DW/8-1:0] s0_av_byteenable_i,
    input  logic            s0_av_read_i,
    input  logic            s0_av_write_i,
    input  logic [DW-1:0]   s0_av_writedata_i,
    input  logic [7:0]      s0_av_burstcount_i,
    output logic [DW-1:0]   s0_av_readdata_o,
    output logic            s0_av_waitrequest_o,
    output logic            s0_av_readdatavalid_o,

    input  logic [AW-1:0]   s1_av_address_i,
    input  logic [DW/8-1:0] s1_av_byteenable_i,
    input  logic            s1_av_read_i,
    input  logic            s1_av_write_i,
    input  logic [DW-1:0]   s1_av_writedata_i,
    input  logic [7:0]      s1_av_burstcount_i,
    output logic [DW-1:0]   s1_av_readdata_o,
    output logic            s1_av_waitrequest_o,
    output logic            s1_av_readdatavalid_o,

    output logic [AW-1:0]   m_av_address_o,
    output logic [DW/8-1:0] m_av_byteenable_o,
    output logic            m_av_read_o,
    output logic            m_av_write_o,
    output logic [DW-1:0]   m_av_writedata_o,
    output logic [7:0]      m_av_burstcount_o,
    input  logic [DW-1:0]   m_av_readdata_i,
    input  logic            m_av_waitrequest_i,
    input  logic            m_av_readdatavalid_i,

    output logic [1:0]      grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_grant, w_grant_nxt;
    logic [7:0] r_cnt,   w_cnt_nxt;
    logic [7:0] r_len,   w_len_nxt;
    logic       r_acc,   w_acc_nxt;   // first beat / read command accepted

    logic            w_req0, w_req1, w_pick1, w_pick_write;
    logic [AW-1:0]   w_sel_addr;
    logic [DW/8-1:0] w_sel_be;
    logic [DW-1:0]   w_sel_wdata;
    logic [7:0]      w_sel_burst, w_burst_fix, w_beat_len, w_cnt_inc;
    logic            w_sel_read, w_sel_write;
    logic            w_fwd_read, w_fwd_write;

    assign w_req0 = s0_av_read_i | s0_av_write_i;
    assign w_req1 = s1_av_read_i | s1_av_write_i;

`ifdef AV_ARB_ROUND_ROBIN_EN
    // r_prio names the requester that wins the next tie
    logic r_prio;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_prio <= 1'b0;
        end else if (r_state == ST_IDLE && (w_req0 || w_req1)) begin
            r_prio <= ~w_pick1;
        end
    end

    assign w_pick1 = w_req1 & (~w_req0 | r_prio);
`else
    assign w_pick1 = w_req1 & ~w_req0;
`endif

    assign w_pick_write = w_pick1 ? s1_av_write_i : s0_av_write_i;

    assign w_sel_addr  = r_grant[1] ? s1_av_address_i    : s0_av_address_i;
    assign w_sel_be    = r_grant[1] ? s1_av_byteenable_i : s0_av_byteenable_i;
    assign w_sel_wdata = r_grant[1] ? s1_av_writedata_i  : s0_av_writedata_i;
    assign w_sel_burst = r_grant[1] ? s1_av_burstcount_i : s0_av_burstcount_i;
    assign w_sel_read  = r_grant[1] ? s1_av_read_i       : s0_av_read_i;
    assign w_sel_write = r_grant[1] ? s1_av_write_i      : s0_av_write_i;

    assign w_burst_fix = (w_sel_burst == 8'd0) ? 8'd1 : w_sel_burst;
    assign w_beat_len  = r_acc ? r_len : w_burst_fix;
    assign w_cnt_inc   = r_cnt + 8'd1;

    // The read command is offered only once per grant
    assign w_fwd_write = (r_state == ST_WRITE) & w_sel_write;
    assign w_fwd_read  = (r_state == ST_READ) & w_sel_read & ~r_acc;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_cnt   <= 8'd0;
            r_len   <= 8'd1;
            r_acc   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_acc_nxt   = r_acc;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_grant_nxt = w_pick1 ? 2'b10 : 2'b01;
                    w_state_nxt = w_pick_write ? ST_WRITE : ST_READ;
                    w_cnt_nxt   = 8'd0;
                    w_acc_nxt   = 1'b0;
                end
            end
            ST_WRITE: begin
                if (w_fwd_write && !m_av_waitrequest_i) begin
                    w_acc_nxt = 1'b1;
                    if (!r_acc) w_len_nxt = w_burst_fix;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == w_beat_len) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 2'b00;
                    end
                end else if (!r_acc && !w_sel_write) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                end
            end
            ST_READ: begin
                if (!r_acc) begin
                    if (w_fwd_read && !m_av_waitrequest_i) begin
                        w_acc_nxt = 1'b1;
                        w_len_nxt = w_burst_fix;
                    end else if (!w_sel_read) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 2'b00;
                    end
                end else if (m_av_readdatavalid_i) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 2'b00;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    always_comb begin
        m_av_address_o        = '0;
        m_av_byteenable_o     = '0;
        m_av_writedata_o      = '0;
        m_av_burstcount_o     = 8'd1;
        m_av_read_o           = 1'b0;
        m_av_write_o          = 1'b0;
        s0_av_waitrequest_o   = 1'b1;
        s1_av_waitrequest_o   = 1'b1;
        s0_av_readdatavalid_o = 1'b0;
        s1_av_readdatavalid_o = 1'b0;
        if (r_state != ST_IDLE) begin
            m_av_address_o      = w_sel_addr;
            m_av_byteenable_o   = w_sel_be;
            m_av_writedata_o    = w_sel_wdata;
            m_av_burstcount_o   = w_sel_burst;
            m_av_read_o         = w_fwd_read;
            m_av_write_o        = w_fwd_write;
            s0_av_waitrequest_o = r_grant[0] ? m_av_waitrequest_i : 1'b1;
            s1_av_waitrequest_o = r_grant[1] ? m_av_waitrequest_i : 1'b1;
        end
        if (r_state == ST_READ) begin
            s0_av_readdatavalid_o = r_grant[0] & m_av_readdatavalid_i;
            s1_av_readdatavalid_o = r_grant[1] & m_av_readdatavalid_i;
        end
    end

    assign s0_av_readdata_o = m_av_readdata_i;
    assign s1_av_readdata_o = m_av_readdata_i;
    assign grant_o          = r_grant;

endmodule

`default_nettype wire

// File: doc/avalon_arbiter_2to1.md
AVALON_ARBITER_2TO1 -- requirements
Module: avalon_arbiter_2to1

Interface
REQ-001 The block SHALL have parameter AW, default 32, the address width.
REQ-002 The block SHALL have parameter DW, default 32, the data width; DW/8 byte lanes.
REQ-003 The block SHALL have the following clock and reset ports:
- wb_clk_i  input  1  sole clock; all state on its rising edge.
- wb_rst_ni  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have the following requester ports, one set per requester n in {0,1}:
- sN_av_address_i  input  AW  address.
- sN_av_byteenable_i  input  DW/8  byte enables.
- sN_av_read_i  input  1  read request.
- sN_av_write_i  input  1  write request.
- sN_av_writedata_i  input  DW  write data.
- sN_av_burstcount_i  input  8  burst length.
- sN_av_readdata_o  output  DW  read data.
- sN_av_waitrequest_o  output  1  stall.
- sN_av_readdatavalid_o  output  1  read beat valid.
REQ-005 The block SHALL have the following shared-slave ports:
- m_av_address_o  output  AW  address.
- m_av_byteenable_o  output  DW/8  byte enables.
- m_av_read_o  output  1  read.
- m_av_write_o  output  1  write.
- m_av_writedata_o  output  DW  write data.
- m_av_burstcount_o  output  8  burst length.
- m_av_readdata_i  input  DW  read data.
- m_av_waitrequest_i  input  1  stall.
- m_av_readdatavalid_i  input  1  read beat valid.
REQ-006 The block SHALL have output grant_o, 2 bits, one-hot owner of the slave; 00 when idle.

Function
REQ-007 The FSM SHALL have states IDLE, WRITE and READ.
REQ-008 In IDLE the block SHALL treat requester n as requesting when sN_av_read_i or sN_av_write_i is high, pick a winner, register grant_o, and go to WRITE if the winner's write_i is high, else READ; the winner's command is forwarded from the next cycle.
REQ-009 If a requester asserts read and write together, the block SHALL treat it as a write.
REQ-010 In WRITE or READ, the m_av_* command outputs SHALL combinationally mirror the granted requester's inputs, and the granted requester's waitrequest SHALL equal m_av_waitrequest_i.
REQ-011 A non-granted requester, or any requester while in IDLE, SHALL see waitrequest=1 and readdatavalid=0.
REQ-012 Both requesters SHALL receive m_av_readdata_i unconditionally; readdatavalid SHALL be routed to the granted requester only.
REQ-013 On the first accepted beat (command high and m_av_waitrequest_i low), the block SHALL latch burstcount, with a value of 0 treated as 1.
REQ-014 In WRITE the block SHALL count accepted write beats and return to IDLE in the cycle after the beat that makes count equal to the latched length; m_av_write_o SHALL be 0 after that beat.
REQ-015 In READ the block SHALL mirror m_av_read_o only until the read command is accepted once, then force it to 0; it SHALL count readdatavalid beats and return to IDLE after the last one. There SHALL be no cross-requester read pipelining.
REQ-016 The beat counter SHALL be 8 bits, SHALL reset to 0 on each grant, and SHALL never wrap; a burst of 255 completes normally.
REQ-017 Outside WRITE/READ, the m_av_* outputs SHALL be driven to 0, with burstcount 1.
REQ-018 A requester that drops its request after grant but before its first accepted beat SHALL release the grant: return to IDLE the next cycle.

Reset
REQ-019 Asserting wb_rst_ni low SHALL asynchronously force IDLE, grant_o=00, counters=0, round-robin pointer=requester 0, m_av_read_o=m_av_write_o=0, and both waitrequest outputs=1.
REQ-020 A reset asserted mid-burst SHALL abandon the burst; read data arriving afterwards SHALL be ignored, with no readdatavalid to any requester.

Configuration
REQ-021 With macro AV_ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: on a tie the requester not granted last wins, and the pointer updates on each grant.
REQ-022 Without AV_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, with requester 0 always winning ties.

Verification
REQ-023 Single write: s0 writes 0xDEADBEEF to 0x10 with burstcount 1 and no slave waits -> m_av_write_o high one cycle with data 0xDEADBEEF; grant_o 01 -> 00; s1 waitrequest=1 throughout.
REQ-024 Write burst of 4 with a 2-cycle slave waitrequest on beat 2 -> exactly 4 accepted beats, data order preserved, then IDLE.
REQ-025 s1 read burst of 3 -> m_av_read_o high until accepted, then 0; 3 readdatavalid pulses to s1 only; s0 sees none.
REQ-026 s0 and s1 both request back-to-back continuously with AV_ARB_ROUND_ROBIN_EN -> grants alternate 01,10,01,10; without the macro -> s0 always wins.
REQ-027 Reset during beat 2 of a 4-beat read -> all outputs at reset values within the reset cycle; later slave readdatavalid is not forwarded; the next request is granted normally.
